// File: rtl/microtile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microtile_pkg
//  Description : Shared constants and types for the microtile select front
//                end: array sizing, select-command bit positions on uio_in,
//                and the tile switch state enumeration.
//  Revision    : 1.0  initial release
// ============================================================================
package microtile_pkg;

    // Largest array the 5-bit index field can address.
    localparam int N_TILES_MAX = 32;
    localparam int SEL_W       = 5;

    // Select command layout on uio_in.
    localparam int STROBE_BIT  = 7;
    localparam int IDX_LSB     = 0;
    localparam int IDX_MSB     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        QUIESCE = 2'd2,
        RESET   = 2'd3
    } tile_state_e;

endpackage : microtile_pkg
`default_nettype wire

// File: rtl/cmd_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_sync_edge
//  Description : Brings the asynchronous select strobe and index pins into the
//                clk domain. Two-flop synchronizer plus edge-detect flop on
//                the strobe; the index follows an identical two-flop path and
//                is captured in the cycle the strobe pulse is produced.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                strobe_in       - raw strobe pin
//                idx_in          - raw index pins
//                strobe_p        - one-cycle pulse, 3 cycles after pin rise
//                idx             - index captured alongside strobe_p
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_sync_edge #(
    parameter int IDX_W = microtile_pkg::IDX_MSB - microtile_pkg::IDX_LSB + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             strobe_p,
    output logic [IDX_W-1:0] idx
);
    import microtile_pkg::*;

    logic             r_strobe_s1;
    logic             r_strobe_s2;
    logic             r_strobe_s3;
    logic             r_strobe_p;
    logic [IDX_W-1:0] r_idx_s1;
    logic [IDX_W-1:0] r_idx_s2;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe_s1 <= 1'b0;
            r_strobe_s2 <= 1'b0;
            r_strobe_s3 <= 1'b0;
            r_strobe_p  <= 1'b0;
            r_idx_s1    <= '0;
            r_idx_s2    <= '0;
            r_idx       <= '0;
        end else begin
            r_strobe_s1 <= strobe_in;
            r_strobe_s2 <= r_strobe_s1;
            r_strobe_s3 <= r_strobe_s2;
            r_strobe_p  <= r_strobe_s2 & ~r_strobe_s3;
            r_idx_s1    <= idx_in;
            r_idx_s2    <= r_idx_s1;
            // Index has seen the same two-flop delay as the strobe, so it is
            // the value that was on the pins at the strobe's rising edge.
            if (r_strobe_s2 & ~r_strobe_s3) begin
                r_idx <= r_idx_s2;
            end
        end
    end

    assign strobe_p = r_strobe_p;
    assign idx      = r_idx;

endmodule : cmd_sync_edge
`default_nettype wire

// File: rtl/microtile_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : microtile_select_ctrl
//  Description : Tile-selection front end. Decodes a strobed select command,
//                sequences quiesce -> reset -> run on a tile switch, and routes
//                the active tile's outputs to the pins.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ena                 - design enable (0 forces IDLE)
//                uio_in              - [7] select strobe, [4:0] tile index
//                tile_uo/uio_out/oe  - flattened per-tile outputs, tile i at
//                                      [8i+7:8i]
//                tile_sel            - index of the current tile
//                tile_ena, tile_rst  - enable / reset to the selected tile
//                uo_out              - registered uo of the running tile
//                uio_out, uio_oe     - combinational uio of the running tile
//                sel_err             - sticky out-of-range request flag
//  Revision    : 1.0  initial release
// ============================================================================
module microtile_select_ctrl #(
    parameter int N_TILES     = 8,
    parameter int SEL_W       = microtile_pkg::SEL_W,
    parameter int QUIESCE_CYC = 2,
    parameter int RST_CYC     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [7:0]           uio_in,
    input  logic [8*N_TILES-1:0] tile_uo,
    input  logic [8*N_TILES-1:0] tile_uio_out,
    input  logic [8*N_TILES-1:0] tile_uio_oe,
    output logic [SEL_W-1:0]     tile_sel,
    output logic                 tile_ena,
    output logic                 tile_rst,
    output logic [7:0]           uo_out,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic                 sel_err
);
    import microtile_pkg::*;

    localparam int c_CNT_MAX = (QUIESCE_CYC > RST_CYC) ? QUIESCE_CYC : RST_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    // Mux arrays span the full index space so any tile_sel value is a legal
    // index; slots beyond N_TILES read as zero.
    localparam int c_ARR     = 2 ** SEL_W;
    localparam logic [SEL_W:0]   c_N_TILES_EXT = (SEL_W + 1)'(N_TILES);
    localparam logic [c_CNT_W-1:0] c_QUIESCE   = c_CNT_W'(QUIESCE_CYC);
    localparam logic [c_CNT_W-1:0] c_RST       = c_CNT_W'(RST_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Per-tile unpack
    // ------------------------------------------------------------------
    logic [7:0] w_uo_arr  [c_ARR];
    logic [7:0] w_uio_arr [c_ARR];
    logic [7:0] w_oe_arr  [c_ARR];

    generate
        for (genvar gi = 0; gi < c_ARR; gi++) begin : g_tile
            if (gi < N_TILES) begin : g_present
                assign w_uo_arr[gi]  = tile_uo[8*gi +: 8];
                assign w_uio_arr[gi] = tile_uio_out[8*gi +: 8];
                assign w_oe_arr[gi]  = tile_uio_oe[8*gi +: 8];
            end else begin : g_absent
                assign w_uo_arr[gi]  = 8'h00;
                assign w_uio_arr[gi] = 8'h00;
                assign w_oe_arr[gi]  = 8'h00;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command synchronizer
    // ------------------------------------------------------------------
    logic             w_strobe_p;
    logic [SEL_W-1:0] w_strobe_idx;

    cmd_sync_edge #(
        .IDX_W (SEL_W)
    ) u_cmd_sync (
        .clk       (clk),
        .rst       (rst),
        .strobe_in (uio_in[STROBE_BIT]),
        .idx_in    (uio_in[IDX_LSB +: SEL_W]),
        .strobe_p  (w_strobe_p),
        .idx       (w_strobe_idx)
    );

    // ------------------------------------------------------------------
    // Switch controller
    // ------------------------------------------------------------------
    tile_state_e        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_tile_sel;
    logic [SEL_W-1:0]   r_pend_idx;
    logic               r_hold_valid;
    logic [SEL_W-1:0]   r_hold_idx;
    logic               r_tile_ena;
    logic               r_tile_rst;
    logic [7:0]         r_uo_out;
    logic               r_sel_err;

    // A live strobe is newer than anything parked in the hold slot.
    logic             w_cmd_valid;
    logic [SEL_W-1:0] w_cmd_idx;
    logic             w_in_range;
    logic             w_switch;

    assign w_cmd_valid = w_strobe_p | r_hold_valid;
    assign w_cmd_idx   = w_strobe_p ? w_strobe_idx : r_hold_idx;
    assign w_in_range  = {1'b0, w_cmd_idx} < c_N_TILES_EXT;
    assign w_switch    = (r_state == RUN) && ena && w_cmd_valid &&
                         w_in_range && (w_cmd_idx != r_tile_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RESET;
            r_cnt        <= c_RST;
            r_tile_sel   <= '0;
            r_pend_idx   <= '0;
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
            r_tile_ena   <= 1'b0;
            r_tile_rst   <= 1'b1;
            r_uo_out     <= 8'h00;
            r_sel_err    <= 1'b0;
        end else begin
            // Only load tile data when the next cycle is still RUN, so uo_out
            // never carries tile data while the tile is disabled.
            r_uo_out <= (ena && (r_state == RUN) && !w_switch) ?
                        w_uo_arr[r_tile_sel] : 8'h00;

            if (!ena) begin
                r_state      <= IDLE;
                r_tile_ena   <= 1'b0;
                r_tile_rst   <= 1'b1;
                r_hold_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= RESET;
                        r_cnt      <= c_RST;
                        r_tile_ena <= 1'b0;
                        r_tile_rst <= 1'b1;
                    end
                    RUN: begin
                        r_hold_valid <= 1'b0;
                        if (w_cmd_valid) begin
                            if (!w_in_range) begin
                                r_sel_err <= 1'b1;
                            end else if (w_cmd_idx != r_tile_sel) begin
                                r_pend_idx <= w_cmd_idx;
                                r_state    <= QUIESCE;
                                r_cnt      <= c_QUIESCE;
                                r_tile_ena <= 1'b0;
                            end
                        end
                    end
                    QUIESCE: begin
                        if (w_strobe_p) begin
                            r_hold_valid <= 1'b1;
                            r_hold_idx   <= w_strobe_idx;
                        end
                        if (r_cnt == c_ONE) begin
                            r_tile_sel <= r_pend_idx;
                            r_state    <= RESET;
                            r_cnt      <= c_RST;
                            r_tile_rst <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    RESET: begin
                        if (w_strobe_p) begin
                            r_hold_valid <= 1'b1;
                            r_hold_idx   <= w_strobe_idx;
                        end
                        if (r_cnt == c_ONE) begin
                            r_state    <= RUN;
                            r_tile_ena <= 1'b1;
                            r_tile_rst <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_tile_ena <= 1'b0;
                        r_tile_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output routing
    // ------------------------------------------------------------------
    logic [7:0] w_oe_sel;
    logic       w_unused_bits;

    assign w_oe_sel = w_oe_arr[r_tile_sel];

    assign tile_sel = r_tile_sel;
    assign tile_ena = r_tile_ena;
    assign tile_rst = r_tile_rst;
    assign uo_out   = r_uo_out;
    assign sel_err  = r_sel_err;
    // r_tile_ena is exactly "state is RUN"; bits [7:5] carry the command
    // pins and must never be driven.
    assign uio_out  = r_tile_ena ? w_uio_arr[r_tile_sel] : 8'h00;
    assign uio_oe   = r_tile_ena ? {3'b000, w_oe_sel[4:0]} : 8'h00;

    assign w_unused_bits = &{1'b0, uio_in[6:5], w_oe_sel[7:5]};

endmodule : microtile_select_ctrl
`default_nettype wire

// File: tb/tb_microtile_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microtile_select_ctrl
//  Description : Self-checking bench for microtile_select_ctrl. Directed
//                scenarios for boot, switch, bad index, strobe coalescing,
//                enable drop and mid-switch reset, then randomized commands
//                checked against a rule-level model of tile selection.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_microtile_select_ctrl;

    localparam int NT = 8;
    localparam int QC = 2;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [7:0]    uio_in;
    logic [8*NT-1:0] tile_uo;
    logic [8*NT-1:0] tile_uio_out;
    logic [8*NT-1:0] tile_uio_oe;
    logic [4:0]    tile_sel;
    logic          tile_ena;
    logic          tile_rst;
    logic [7:0]    uo_out;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;
    logic          sel_err;

    logic [7:0] m_uo  [NT];
    logic [7:0] m_uio [NT];
    logic [7:0] m_oe  [NT];

    int checks   = 0;
    int failures = 0;
    int m_sel    = 0;
    int m_err    = 0;

    always #5 clk = ~clk;

    always_comb begin
        tile_uo      = '0;
        tile_uio_out = '0;
        tile_uio_oe  = '0;
        for (int i = 0; i < NT; i++) begin
            tile_uo[8*i +: 8]      = m_uo[i];
            tile_uio_out[8*i +: 8] = m_uio[i];
            tile_uio_oe[8*i +: 8]  = m_oe[i];
        end
    end

    microtile_select_ctrl #(
        .N_TILES     (NT),
        .SEL_W       (5),
        .QUIESCE_CYC (QC),
        .RST_CYC     (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .uio_in       (uio_in),
        .tile_uo      (tile_uo),
        .tile_uio_out (tile_uio_out),
        .tile_uio_oe  (tile_uio_oe),
        .tile_sel     (tile_sel),
        .tile_ena     (tile_ena),
        .tile_rst     (tile_rst),
        .uo_out       (uo_out),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe),
        .sel_err      (sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raise the strobe with an index for hi cycles, then drop the strobe.
    task automatic pulse(input logic [4:0] idx, input int hi);
        uio_in = {1'b1, 2'b00, idx};
        repeat (hi) @(negedge clk);
        uio_in[7] = 1'b0;
    endtask

    // Observe w cycles starting now: quiesce cycles (ena and rst both low),
    // reset cycles, enable drops, and output-gating violations.
    task automatic measure(input int w, output int nq, output int nr,
                           output int nd, output int nbad);
        logic pe;
        nq = 0; nr = 0; nd = 0; nbad = 0;
        pe = tile_ena;
        for (int i = 0; i < w; i++) begin
            if (!tile_ena && !tile_rst) nq++;
            if (tile_rst) nr++;
            if (pe && !tile_ena) nd++;
            if (tile_ena && tile_rst) nbad++;
            if (uio_oe[7:5] != 3'b000) nbad++;
            if (!tile_ena && (uo_out != 8'h00 || uio_oe != 8'h00 || uio_out != 8'h00)) nbad++;
            pe = tile_ena;
            @(negedge clk);
        end
    endtask

    // Selection rule: bad index flags error, same index is ignored,
    // anything else switches.
    task automatic apply_rule(input int idx, inout int sel, inout int err, inout int sw);
        if (idx >= NT) err = 1;
        else if (idx != sel) begin
            sel = idx;
            sw++;
        end
    endtask

    task automatic check_route(input string tag);
        logic [7:0] e_oe;
        e_oe      = m_oe[m_sel];
        e_oe[7:5] = 3'b000;
        chk({tag, "_sel"},  tile_sel, m_sel);
        chk({tag, "_err"},  sel_err,  m_err);
        chk({tag, "_ena"},  tile_ena, 1);
        chk({tag, "_uo"},   uo_out,   m_uo[m_sel]);
        chk({tag, "_uio"},  uio_out,  m_uio[m_sel]);
        chk({tag, "_oe"},   uio_oe,   e_oe);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sel"},  tile_sel, 0);
        chk({tag, "_ena"},  tile_ena, 0);
        chk({tag, "_rst"},  tile_rst, 1);
        chk({tag, "_uo"},   uo_out,   0);
        chk({tag, "_uio"},  uio_out,  0);
        chk({tag, "_oe"},   uio_oe,   0);
        chk({tag, "_err"},  sel_err,  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nq, nr, nd, nbad, sw, idx1, idx2, dual;

        for (int i = 0; i < NT; i++) begin
            m_uo[i]  = 8'($urandom);
            m_uio[i] = 8'($urandom);
            m_oe[i]  = 8'($urandom);
        end
        m_uo[0] = 8'hA5;
        m_uo[3] = 8'h3C;
        rst = 1'b1; ena = 1'b1; uio_in = 8'h00;

        // Reset state and boot of tile 0
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        n = 0;
        while (tile_rst && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("boot_rst_cycles", n, RC);
        chk("boot_ena", tile_ena, 1);
        chk("boot_uo_first", uo_out, 0);
        @(negedge clk);
        chk("boot_uo", uo_out, 8'hA5);
        m_sel = 0; m_err = 0;
        check_route("boot");

        // Switch to tile 3
        fork
            pulse(5'd3, 2);
            measure(30, nq, nr, nd, nbad);
        join
        chk("sw3_quiesce", nq, QC);
        chk("sw3_reset", nr, RC);
        chk("sw3_drops", nd, 1);
        chk("sw3_bad", nbad, 0);
        m_sel = 3;
        chk("sw3_uo", uo_out, 8'h3C);
        check_route("sw3");

        // Out-of-range index
        fork
            pulse(5'd9, 2);
            measure(30, nq, nr, nd, nbad);
        join
        chk("bad_drops", nd, 0);
        chk("bad_reset", nr, 0);
        m_err = 1;
        check_route("bad");

        // 2, then 5 and 6 during RESET: newest held strobe wins
        fork
            begin
                pulse(5'd2, 1);
                repeat (3) @(negedge clk);
                pulse(5'd5, 1);
                @(negedge clk);
                pulse(5'd6, 1);
            end
            measure(50, nq, nr, nd, nbad);
        join
        chk("coal_drops", nd, 2);
        chk("coal_quiesce", nq, 2*QC);
        chk("coal_reset", nr, 2*RC);
        chk("coal_bad", nbad, 0);
        m_sel = 6;
        check_route("coal");

        // Enable drop in RUN, then re-enable
        ena = 1'b0;
        @(negedge clk);
        chk("idle_ena", tile_ena, 0);
        chk("idle_rst", tile_rst, 1);
        chk("idle_uo", uo_out, 0);
        chk("idle_oe", uio_oe, 0);
        ena = 1'b1;
        @(negedge clk);
        measure(20, nq, nr, nd, nbad);
        chk("reen_reset", nr, RC);
        chk("reen_quiesce", nq, 0);
        chk("reen_bad", nbad, 0);
        check_route("reen");

        // Reset during QUIESCE towards tile 4
        pulse(5'd4, 2);
        n = 0;
        while (!(tile_ena == 1'b0 && tile_rst == 1'b0) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("mid_in_quiesce", (n < 20), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        measure(30, nq, nr, nd, nbad);
        chk("mid_reset", nr, RC);
        chk("mid_quiesce", nq, 0);
        chk("mid_drops", nd, 0);
        m_sel = 0; m_err = 0;
        check_route("mid");

        // Randomized commands, optionally a second one landing mid-switch
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NT; i++) begin
                m_uo[i]  = 8'($urandom);
                m_uio[i] = 8'($urandom);
                m_oe[i]  = 8'($urandom);
            end
            @(negedge clk);
            idx1 = int'($urandom_range(0, 11));
            idx2 = int'($urandom_range(0, 11));
            dual = int'($urandom_range(0, 1));
            fork
                begin
                    pulse(5'(idx1), 2);
                    if (dual != 0) begin
                        repeat (2) @(negedge clk);
                        pulse(5'(idx2), 2);
                    end
                end
                measure(45, nq, nr, nd, nbad);
            join
            sw = 0;
            apply_rule(idx1, m_sel, m_err, sw);
            if (dual != 0) apply_rule(idx2, m_sel, m_err, sw);
            chk("rnd_drops", nd, sw);
            chk("rnd_quiesce", nq, sw*QC);
            chk("rnd_reset", nr, sw*RC);
            chk("rnd_bad", nbad, 0);
            check_route("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_microtile_select_ctrl
`default_nettype wire
